asp_rx_buffer: RTL and testbench

ASP_RX_BUFFER -- requirements
Module: asp_rx_buffer

---
 rtl/asp_rx_buffer.sv | 172 +++++++++++++++++
 tb/tb_asp_rx_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/asp_rx_buffer.sv
// ---------------------------------------------------------------------------
// asp_rx_buffer
//
// Receive-side buffer between a tagged network link and a host. Each network
// word carries a data field in its upper DATA_SIZE bits and a tag in its low
// TAG_SIZE bits. Words whose tag equals TAG_VALUE are queued in a DEPTH-entry
// FIFO for the host. All other words are dropped.
//
// Each offered word is answered one cycle later with an ACK or NACK pulse.
//
// Parameters:
//   DATA_SIZE  host data width
//   TAG_SIZE   network tag width
//   TAG_VALUE  tag accepted by this receiver
//   DEPTH      FIFO depth in words (power of two, >= 2)
//
// Ports:
//   clk                    rising-edge clock
//   reset                  asynchronous, active-low reset
//   network_data_ready_in  network word valid this cycle
//   network_data_tag_in    {data, tag}, with the tag in the low bits
//   network_ACK_out        one-cycle pulse: previous word accepted
//   network_NACK_out       one-cycle pulse: previous word rejected
//   host_data_ready_out    FIFO non-empty; host_data_out valid
//   host_data_accept_in    host pops the head word when ready is high
//   host_data_out          FIFO head word (0 when empty)
//   tag_error_out          one-cycle pulse on a tag mismatch
//   overflow_out           sticky: a good word was dropped because FIFO full
//   fifo_count_out         number of words held, 0..DEPTH
//   tag_error_count_out    saturating mismatch counter
//
// Optional feature:
//   Define ASP_RX_ERRCNT_EN to build the saturating tag error counter.
//   Without the macro, tag_error_count_out is tied to zero.
// ---------------------------------------------------------------------------
module asp_rx_buffer #(
    parameter int                  DATA_SIZE = 32,
    parameter int                  TAG_SIZE  = 8,
    parameter logic [TAG_SIZE-1:0] TAG_VALUE = 8'hAB,
    parameter int                  DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          network_data_ready_in,
    input  logic [DATA_SIZE+TAG_SIZE-1:0] network_data_tag_in,
    output logic                          network_ACK_out,
    output logic                          network_NACK_out,
    output logic                          host_data_ready_out,
    input  logic                          host_data_accept_in,
    output logic [DATA_SIZE-1:0]          host_data_out,
    output logic                          tag_error_out,
    output logic                          overflow_out,
    output logic [$clog2(DEPTH):0]        fifo_count_out,
    output logic [7:0]                    tag_error_count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ack_q, ack_d;
    logic          nack_q, nack_d;
    logic          tagErr_q, tagErr_d;
    logic          overflow_q, overflow_d;

    logic                 tagMatch;
    logic                 pop;
    logic                 push;
    logic [DATA_SIZE-1:0] inData;

    assign inData   = network_data_tag_in[DATA_SIZE+TAG_SIZE-1:TAG_SIZE];
    assign tagMatch = (network_data_tag_in[TAG_SIZE-1:0] == TAG_VALUE);

    // A pop frees a slot in the same edge. This lets a full FIFO still
    // accept a word when the host drains one at the same time.
    assign pop  = host_data_accept_in && (count_q != '0);
    assign push = network_data_ready_in && tagMatch &&
                  ((count_q < CW'(DEPTH)) || pop);

    // Next-state logic for the pointers, the count and the response pulses.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        ack_d      = push;
        nack_d     = network_data_ready_in && !push;
        tagErr_d   = network_data_ready_in && !tagMatch;
        overflow_d = overflow_q;

        if (push) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A well-tagged word is rejected only when there is no room for it.
        if (network_data_ready_in && tagMatch && !push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            tagErr_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            tagErr_q   <= tagErr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset. An entry is only ever read after it is written,
    // and the output is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= inData;
        end
    end

`ifdef ASP_RX_ERRCNT_EN
    logic [7:0] errCnt_q, errCnt_d;

    always_comb begin
        errCnt_d = errCnt_q;
        if (network_data_ready_in && !tagMatch && (errCnt_q != 8'hFF)) begin
            errCnt_d = errCnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            errCnt_q <= '0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign tag_error_count_out = errCnt_q;
`else
    assign tag_error_count_out = '0;
`endif

    assign network_ACK_out     = ack_q;
    assign network_NACK_out    = nack_q;
    assign tag_error_out       = tagErr_q;
    assign overflow_out        = overflow_q;
    assign fifo_count_out      = count_q;
    assign host_data_ready_out = (count_q != '0);
    assign host_data_out       = (count_q != '0) ? mem_q[rdPtr_q] : '0;

endmodule

// File: tb/tb_asp_rx_buffer.sv
// ---------------------------------------------------------------------------
// tb_asp_rx_buffer
//
// Scoreboard bench for asp_rx_buffer (32-bit data, 8-bit tag 8'hAB, depth 4).
//
// The driver changes inputs on falling edges. For each cycle it updates a
// queue-based reference model and pushes the expected post-edge state onto
// respQ. A monitor runs 1 ns after each rising edge. It pops respQ and
// compares the entry with the DUT outputs.
//
// Define ASP_RX_ERRCNT_EN to enable the tag error counter in both the DUT and
// the bench.
// ---------------------------------------------------------------------------
module tb_asp_rx_buffer;

    logic        clk;
    logic        reset;
    logic        netValid;
    logic [39:0] netWord;
    logic        netAck;
    logic        netNack;
    logic        hostReady;
    logic        hostAccept;
    logic [31:0] hostData;
    logic        tagErr;
    logic        overflow;
    logic [2:0]  fifoCount;
    logic [7:0]  tagErrCount;

    typedef struct {
        logic        ack;
        logic        nack;
        logic        tagErr;
        logic        ovf;
        int          count;
        logic [31:0] head;
        int          errCnt;
    } exp_t;

    exp_t        respQ[$];
    logic [31:0] mq[$];
    logic        ovfM;
    int          errCntM;
    int          checks;
    int          errors;

    asp_rx_buffer #(
        .DATA_SIZE(32),
        .TAG_SIZE(8),
        .TAG_VALUE(8'hAB),
        .DEPTH(4)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .network_data_ready_in(netValid),
        .network_data_tag_in  (netWord),
        .network_ACK_out      (netAck),
        .network_NACK_out     (netNack),
        .host_data_ready_out  (hostReady),
        .host_data_accept_in  (hostAccept),
        .host_data_out        (hostData),
        .tag_error_out        (tagErr),
        .overflow_out         (overflow),
        .fifo_count_out       (fifoCount),
        .tag_error_count_out  (tagErrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus. Apply the reference model's rules for it,
    // queue the expected state after the next rising edge, and wait until the
    // following falling edge.
    task automatic applyStimulus(input logic valid, input logic [39:0] word, input logic accept);
        exp_t e;
        logic doPop;
        logic match;
        logic doPush;
        netValid   = valid;
        netWord    = word;
        hostAccept = accept;
        doPop  = accept && (mq.size() > 0);
        match  = (word[7:0] == 8'hAB);
        doPush = valid && match && ((mq.size() < 4) || doPop);
        if (doPop) void'(mq.pop_front());
        if (doPush) mq.push_back(word[39:8]);
        if (valid && match && !doPush) ovfM = 1'b1;
`ifdef ASP_RX_ERRCNT_EN
        if (valid && !match && errCntM < 255) errCntM++;
`endif
        e.ack    = doPush;
        e.nack   = valid && !doPush;
        e.tagErr = valid && !match;
        e.ovf    = ovfM;
        e.count  = mq.size();
        e.head   = (mq.size() > 0) ? mq[0] : 32'h0;
        e.errCnt = errCntM;
        respQ.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [39:0] randWord(input logic goodTag);
        logic [7:0] tag;
        if (goodTag) begin
            tag = 8'hAB;
        end else begin
            tag = 8'($urandom_range(0, 254));
            if (tag >= 8'hAB) tag = tag + 8'd1;
        end
        return {32'($urandom), tag};
    endfunction

    // Monitor: compare the DUT outputs with the scoreboard after every edge
    // for which the driver queued an expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (respQ.size() > 0) begin
            e = respQ.pop_front();
            checkOutput("ack", 64'(netAck), 64'(e.ack));
            checkOutput("nack", 64'(netNack), 64'(e.nack));
            checkOutput("tag_error", 64'(tagErr), 64'(e.tagErr));
            checkOutput("overflow", 64'(overflow), 64'(e.ovf));
            checkOutput("count", 64'(fifoCount), 64'(e.count));
            checkOutput("ready", 64'(hostReady), 64'(e.count != 0));
            checkOutput("head", 64'(hostData), 64'(e.head));
            checkOutput("err_count", 64'(tagErrCount), 64'(e.errCnt));
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        ovfM       = 1'b0;
        errCntM    = 0;
        reset      = 1'b1;
        netValid   = 1'b0;
        netWord    = '0;
        hostAccept = 1'b0;
        #1 reset = 1'b0;
        #2;
        checkOutput("reset_count", 64'(fifoCount), 64'd0);
        checkOutput("reset_ready", 64'(hostReady), 64'd0);
        checkOutput("reset_data", 64'(hostData), 64'd0);
        checkOutput("reset_pulses", 64'({netAck, netNack, tagErr, overflow}), 64'd0);
        checkOutput("reset_errcnt", 64'(tagErrCount), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single good word, then a bad tag, then drain.
        applyStimulus(1'b1, 40'h00001234AB, 1'b0);
        applyStimulus(1'b1, 40'h00001234AC, 1'b0);
        applyStimulus(1'b0, 40'h0, 1'b1);
        applyStimulus(1'b0, 40'h0, 1'b0);

        // Five back-to-back good words overflow a depth-4 FIFO.
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, {32'(i), 8'hAB}, 1'b0);
        // When full, a push with a pop in the same cycle is accepted.
        applyStimulus(1'b1, {32'd6, 8'hAB}, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 40'h0, 1'b1);
        // Push and pop together at count 1.
        applyStimulus(1'b1, {32'd7, 8'hAB}, 1'b0);
        applyStimulus(1'b1, {32'd8, 8'hAB}, 1'b1);
        applyStimulus(1'b0, 40'h0, 1'b1);
        applyStimulus(1'b0, 40'h0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, randWord($urandom_range(0, 3) != 0),
                          $urandom_range(0, 9) < 4);
        end

        // Drain, buffer three words, then assert reset between edges while
        // an ACK pulse is being driven.
        for (int i = 0; i < 6 && mq.size() > 0; i++) applyStimulus(1'b0, 40'h0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, {32'(100 + i), 8'hAB}, 1'b0);
        @(posedge clk);
        #2;
        netValid   = 1'b0;
        hostAccept = 1'b0;
        reset      = 1'b0;
        #1;
        checkOutput("midreset_count", 64'(fifoCount), 64'd0);
        checkOutput("midreset_ready", 64'(hostReady), 64'd0);
        checkOutput("midreset_data", 64'(hostData), 64'd0);
        checkOutput("midreset_pulses", 64'({netAck, netNack, tagErr, overflow}), 64'd0);
        checkOutput("midreset_errcnt", 64'(tagErrCount), 64'd0);
        #4 reset = 1'b1;
        mq.delete();
        ovfM    = 1'b0;
        errCntM = 0;
        @(negedge clk);

        // Many mismatches: the error counter saturates and the FIFO stays empty.
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, randWord(1'b0), 1'b0);
        applyStimulus(1'b0, 40'h0, 1'b0);

        // A little more random traffic after saturation.
        for (int i = 0; i < 100; i++) begin
            applyStimulus($urandom_range(0, 1) == 1, randWord($urandom_range(0, 2) != 0),
                          $urandom_range(0, 1) == 1);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(respQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
